muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 162 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Sequential 32-bit unsigned multiply/divide unit.
//
// Purpose: accepts one operation in IDLE. Multiply runs shift-add, LSB first.
// Divide runs restoring division, MSB first. Each takes 32 iteration edges
// and then spends one cycle in DONE. Divide by zero finishes after a single
// edge. HI/LO are written only on the edge that enters DONE.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   start_i    request pulse, sampled only in IDLE
//   op_i       0 = multiply, 1 = divide (sampled with start_i)
//   a_i        multiplicand / dividend (sampled with start_i)
//   b_i        multiplier / divisor (sampled with start_i)
//   rd_sel_i   result select: 0 = LO, 1 = HI
//   busy_o     high while not IDLE
//   done_o     one-cycle completion pulse (DONE state)
//   hi_o       product[63:32] or remainder
//   lo_o       product[31:0] or quotient
//   result_o   lo_o or hi_o, selected combinationally by rd_sel_i
module muldiv_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        rd_sel_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] result_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: the low half holds dividend bits shifting out and quotient bits
  // shifting in.
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [31:0] div_rem_next;
  logic [31:0] div_quo_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? a_q : 32'd0)};
    mul_next = {mul_sum, acc_q[31:1]};

    // div_shift is the 33-bit partial remainder. After a successful subtract
    // the difference is below b, so 32 bits are enough to hold it.
    div_shift    = {rem_q, acc_q[31]};
    div_ge       = (div_shift >= {1'b0, b_q});
    div_sub      = div_shift[31:0] - b_q;
    div_rem_next = div_ge ? div_sub : div_shift[31:0];
    div_quo_next = {acc_q[30:0], div_ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d   = a_i;
          b_d   = b_i;
          cnt_d = 5'd0;
          rem_d = 32'd0;
          if (op_i) begin
            state_d = StDiv;
            acc_d   = {32'd0, a_i};
          end else begin
            state_d = StMul;
            acc_d   = {32'd0, b_i};
          end
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
          hi_d    = mul_next[63:32];
          lo_d    = mul_next[31:0];
        end
      end
      StDiv: begin
        if (b_q == 32'd0) begin
          state_d = StDone;
          hi_d    = a_q;
          lo_d    = 32'hFFFF_FFFF;
        end else begin
          rem_d = div_rem_next;
          acc_d = {32'd0, div_quo_next};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = StDone;
            hi_d    = div_rem_next;
            lo_d    = div_quo_next;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      rem_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone);
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign result_o = rd_sel_i ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        rd_sel_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] result_o;

  muldiv_sequencer dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .rd_sel_i (rd_sel_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_hi = 32'd0;
  logic [31:0] prev_lo = 32'd0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic and the divide-by-zero rule.
  function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    if (!op) begin
      p = {32'd0, a} * {32'd0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      h = a;
      l = 32'hFFFF_FFFF;
    end else begin
      h = a % b;
      l = a / b;
    end
  endfunction

  // One operation; inj != 0 pulses a conflicting start in that busy cycle.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input int inj);
    logic [31:0] eh, el;
    int cyc, dn, done_at, busy_n, exp_len;
    model(op, a, b, eh, el);
    exp_len = (op && b == 32'd0) ? 2 : 33;
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    cyc = 0; dn = 0; done_at = 0; busy_n = 0;
    do begin
      @(negedge clk_i);
      cyc++;
      if (busy_o) busy_n++;
      if (done_o) begin
        dn++;
        done_at = cyc;
      end
      if (cyc == 10 && exp_len == 33) begin
        chk("hold_hi_midop", hi_o, prev_hi);
        chk("hold_lo_midop", lo_o, prev_lo);
      end
      start_i = (inj != 0 && cyc == inj);
      if (start_i) begin
        op_i = ~op;
        a_i  = ~a;
        b_i  = b + 32'd1;
      end
    end while (busy_o && cyc < 100);
    chk("busy_cycles", busy_n, exp_len);
    chk("done_cycle", done_at, exp_len);
    chk("done_pulses", dn, 1);
    chk("hi", hi_o, eh);
    chk("lo", lo_o, el);
    rd_sel_i = 1'b0;
    #1 chk("result_lo", result_o, el);
    rd_sel_i = 1'b1;
    #1 chk("result_hi", result_o, eh);
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    int cnt, dn;
    logic rop;
    logic [31:0] ra, rb;

    vecs[0] = '{1'b0, 32'd12, 32'd4, 32'd0, 32'd48};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{1'b1, 32'd13, 32'd4, 32'd1, 32'd3};
    vecs[3] = '{1'b1, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 32'd0, 32'd12345, 32'd0, 32'd0};
    vecs[5] = '{1'b0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0};
    vecs[6] = '{1'b1, 32'd100, 32'd1, 32'd0, 32'd100};
    vecs[7] = '{1'b1, 32'd5, 32'd9, 32'd5, 32'd0};
    vecs[8] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1};
    vecs[9] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0};

    rst_i = 1'b1; start_i = 1'b0; op_i = 1'b0; a_i = '0; b_i = '0; rd_sel_i = 1'b0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Table vectors; the tb-side expectations are also cross-checked with the model.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] mh, ml;
      model(vecs[i].op, vecs[i].a, vecs[i].b, mh, ml);
      if (mh !== vecs[i].hi || ml !== vecs[i].lo)
        $display("note: table row %0d disagrees with model", i);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0);
      chk("table_hi", hi_o, vecs[i].hi);
      chk("table_lo", lo_o, vecs[i].lo);
    end

    // Start while busy must be ignored.
    run_op(1'b0, 32'd1234, 32'd5678, 10);
    run_op(1'b1, 32'd1000, 32'd7, 10);

    // Start held across E33 is refused; accepted at E34.
    @(negedge clk_i);
    start_i = 1'b1; op_i = 1'b0; a_i = 32'd3; b_i = 32'd5;
    @(negedge clk_i);
    start_i = 1'b0;
    cnt = 1;
    while (!done_o && cnt < 40) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("e33_done_at", cnt, 33);
    chk("e33_first_lo", lo_o, 15);
    start_i = 1'b1; a_i = 32'd6; b_i = 32'd7;
    @(negedge clk_i);
    chk("e33_not_accepted", busy_o, 0);
    @(negedge clk_i);
    chk("e34_accepted", busy_o, 1);
    start_i = 1'b0;
    cnt = 0;
    while (!done_o && cnt < 40) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("e34_done_at", cnt, 32);
    chk("e34_hi", hi_o, 0);
    chk("e34_lo", lo_o, 42);
    @(negedge clk_i);
    prev_hi = 32'd0;
    prev_lo = 32'd42;

    // Asynchronous reset mid-multiply.
    @(negedge clk_i);
    start_i = 1'b1; op_i = 1'b0; a_i = 32'd9; b_i = 32'd9;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (14) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_hi", hi_o, 0);
    chk("arst_lo", lo_o, 0);
    dn = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o) dn++;
    end
    chk("arst_no_done", dn, 0);
    rst_i = 1'b0;
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    run_op(1'b0, 32'd21, 32'd2, 0);

    // Randomized operations against the model.
    for (int i = 0; i < 20; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = 32'd0;
        2: rb = $urandom_range(1, 16);
        default: ;
      endcase
      run_op(rop, ra, rb, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
